// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM states, address width, R/W and ACK bit levels.
package i2c_pkg;
  localparam int ADDR_W = 7;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    WAIT_STOP
  } state_t;
endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer, optional persistence filter (I2C_SLAVE_GLITCH_FILTER_EN) and edge/START/STOP detection.
// Events are registered: bus edge to event is SYNC_STAGES+1 clks (+FILT_LEN with the filter); no backpressure.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILT_LEN < 2) begin : g_bad_filt
    $error("FILT_LEN must be at least 2");
  end

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_f;
  logic                   sda_f;
  logic                   scl_d;
  logic                   sda_d;

  // Idle bus level is high, so reset everything to 1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [FILT_LEN-2:0] scl_hist;
  logic [FILT_LEN-2:0] sda_hist;
  logic [FILT_LEN-1:0] scl_win;
  logic [FILT_LEN-1:0] sda_win;
  logic                scl_filt;
  logic                sda_filt;

  assign scl_win = {scl_hist, scl_sync[SYNC_STAGES-1]};
  assign sda_win = {sda_hist, sda_sync[SYNC_STAGES-1]};

  // Output only follows the line once FILT_LEN consecutive samples agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_filt <= 1'b1;
      sda_filt <= 1'b1;
    end else begin
      scl_hist <= scl_win[FILT_LEN-2:0];
      sda_hist <= sda_win[FILT_LEN-2:0];
      if (&scl_win)       scl_filt <= 1'b1;
      else if (~|scl_win) scl_filt <= 1'b0;
      if (&sda_win)       sda_filt <= 1'b1;
      else if (~|sda_win) sda_filt <= 1'b0;
    end
  end

  assign scl_f = scl_filt;
  assign sda_f = sda_filt;
`else
  assign scl_f = scl_sync[SYNC_STAGES-1];
  assign sda_f = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_s     <= 1'b1;
    end else begin
      scl_d     <= scl_f;
      sda_d     <= sda_f;
      scl_rise  <= scl_f & ~scl_d;
      scl_fall  <= ~scl_f & scl_d;
      start_det <= scl_f & scl_d & sda_d & ~sda_f;
      stop_det  <= scl_f & scl_d & ~sda_d & sda_f;
      sda_s     <= sda_f;
    end
  end
endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, write bytes to rx_data, read bytes from tx_data; open-drain SDA, never stretches SCL.
// Optional glitch filter via `define I2C_SLAVE_GLITCH_FILTER_EN; tx_data must be valid whenever tx_req pulses.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                SYNC_STAGES = 2,
  parameter int                FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);
  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  state_t     state, state_n;
  logic [7:0] shift, shift_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic [2:0] cnt, cnt_n;
  logic       rw, rw_n;
  logic       phase, phase_n;
  logic       oe_n, busy_n, rx_valid_n;
  logic [7:0] rx_data_n;
  logic [7:0] rx_byte;
  logic       load_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      tx_shift <= '0;
      cnt      <= '0;
      rw       <= RW_WRITE;
      phase    <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      tx_shift <= tx_shift_n;
      cnt      <= cnt_n;
      rw       <= rw_n;
      phase    <= phase_n;
      sda_oe   <= oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    shift_n    = shift;
    tx_shift_n = tx_shift;
    cnt_n      = cnt;
    rw_n       = rw;
    phase_n    = phase;
    oe_n       = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    busy_n     = busy;
    load_tx    = 1'b0;
    rx_byte    = {shift[6:0], sda_s};

    // Bus conditions beat any coincident SCL edge.
    if (stop_det) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      oe_n    = 1'b0;
    end else if (start_det) begin
      state_n = ADDR;
      cnt_n   = '0;
      busy_n  = 1'b0;
      oe_n    = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: if (scl_rise) begin
          shift_n = rx_byte;
          cnt_n   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (shift[6:0] == SLAVE_ADDR && SLAVE_ADDR != 7'h00) begin
              state_n = ADDR_ACK;
              busy_n  = 1'b1;
              rw_n    = sda_s;
              phase_n = 1'b0;
            end else begin
              state_n = IDLE;
              oe_n    = 1'b0;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!phase) begin
            oe_n    = 1'b1;
            phase_n = 1'b1;
          end else if (rw == RW_WRITE) begin
            oe_n    = 1'b0;
            cnt_n   = '0;
            state_n = RX;
          end else begin
            load_tx = 1'b1;
          end
        end
        RX: if (scl_rise) begin
          shift_n = rx_byte;
          cnt_n   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            rx_data_n  = rx_byte;
            rx_valid_n = 1'b1;
            state_n    = RX_ACK;
            phase_n    = 1'b0;
          end
        end
        RX_ACK: if (scl_fall) begin
          if (!phase) begin
            oe_n    = 1'b1;
            phase_n = 1'b1;
          end else begin
            oe_n    = 1'b0;
            cnt_n   = '0;
            state_n = RX;
          end
        end
        TX: if (scl_fall) begin
          if (cnt == 3'd7) begin
            oe_n    = 1'b0;
            phase_n = 1'b0;
            state_n = TX_ACK;
          end else begin
            oe_n       = ~tx_shift[6];
            tx_shift_n = {tx_shift[6:0], 1'b0};
            cnt_n      = cnt + 3'd1;
          end
        end
        // phase records that the master ACKed, so the next fall reloads.
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_NACK) begin
              state_n = WAIT_STOP;
              oe_n    = 1'b0;
            end else begin
              phase_n = 1'b1;
            end
          end else if (scl_fall && phase) begin
            load_tx = 1'b1;
          end
        end
        WAIT_STOP: ;
        default: state_n = IDLE;
      endcase
    end

    // MSB goes out on the same fall that tx_data is captured.
    if (load_tx) begin
      tx_shift_n = tx_data;
      oe_n       = ~tx_data[7];
      cnt_n      = '0;
      state_n    = TX;
    end
  end

  assign tx_req = load_tx & ~rst;
endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master with a transaction-level model of the target; directed plan followed by random transactions.
module tb_i2c_slave;
  localparam int H = 12;
  localparam logic [6:0] SLAVE_ADDR = 7'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       scl_in, sda_in;
  logic       sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave dut (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .sda_oe  (sda_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .busy    (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state: what an ideal target must be doing at transaction level.
  bit         m_busy = 0;
  bit         m_rw = 0;
  logic [7:0] m_tx_cur = 8'h00;
  logic [7:0] tx_next = 8'h00;
  logic [7:0] rxq[$];
  int         rxv_cnt = 0;
  int         txreq_cnt = 0;
  int         exp_txreq = 0;

  logic chk = 1'b0, chk_b = 1'b0, exp_oe = 1'b0, exp_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("sda_oe", {31'd0, sda_oe}, {31'd0, exp_oe});
      if (chk_b) check("busy", {31'd0, busy}, {31'd0, exp_busy});
    end
    if (rx_valid) begin
      rxv_cnt++;
      if (rxq.size() == 0) check("rx_valid_spurious", {31'd0, rx_valid}, 32'd0);
      else check("rx_data", {24'd0, rx_data}, {24'd0, rxq.pop_front()});
    end
    if (tx_req) txreq_cnt++;
  end

  // One SCL clock; entered and left with SCL low. Expectations are checked mid-high.
  task automatic bit_cycle(input logic b, input logic eo, input logic cb, input logic eb,
                           input logic glitch, output logic smp);
    repeat (2) @(posedge clk);
    sda_m = b;
    if (glitch) begin
      repeat (3) @(posedge clk);
      scl_m = 1'b1;
      @(posedge clk);
      scl_m = 1'b0;
      repeat (H - 6) @(posedge clk);
    end else begin
      repeat (H - 2) @(posedge clk);
    end
    scl_m = 1'b1;
    repeat (H / 2) @(posedge clk);
    smp      = sda_in;
    tx_data  = tx_next;
    exp_oe   = eo;
    exp_busy = eb;
    chk_b    = cb;
    chk      = 1'b1;
    @(posedge clk);
    chk   = 1'b0;
    chk_b = 1'b0;
    repeat (H / 2 - 1) @(posedge clk);
    scl_m = 1'b0;
  endtask

  task automatic m_start();
    if (scl_m == 1'b0) begin
      repeat (2) @(posedge clk);
      sda_m = 1'b1;
      repeat (H - 2) @(posedge clk);
      scl_m = 1'b1;
      repeat (H / 2) @(posedge clk);
    end
    sda_m = 1'b0;
    repeat (H / 2) @(posedge clk);
    scl_m  = 1'b0;
    m_busy = 0;
  endtask

  task automatic m_stop();
    repeat (2) @(posedge clk);
    sda_m = 1'b0;
    repeat (H - 2) @(posedge clk);
    scl_m = 1'b1;
    repeat (H / 2) @(posedge clk);
    sda_m = 1'b1;
    repeat (H) @(posedge clk);
    m_busy = 0;
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_sda_oe", {31'd0, sda_oe}, 32'd0);
  endtask

  task automatic m_write_byte(input logic [7:0] b, input bit is_addr, input int glitch_at);
    logic smp;
    bit   exp_ack;
    if (is_addr) exp_ack = (b[7:1] == SLAVE_ADDR) && (b[7:1] != 7'h00);
    else         exp_ack = m_busy && (m_rw == 0);
    if (!is_addr && exp_ack) rxq.push_back(b);
    for (int i = 7; i >= 0; i--)
      bit_cycle(b[i], 1'b0, !is_addr, m_busy, (i == glitch_at), smp);
    if (is_addr) begin
      m_busy = exp_ack;
      m_rw   = b[0];
      if (exp_ack && b[0]) begin
        exp_txreq++;
        m_tx_cur = tx_next;
      end
    end
    bit_cycle(1'b1, exp_ack, 1'b1, m_busy, 1'b0, smp);
    if (is_addr) check("addr_ack", {31'd0, smp}, {31'd0, !exp_ack});
    else         check("data_ack", {31'd0, smp}, {31'd0, !exp_ack});
  endtask

  task automatic m_read_byte(input logic mack, output logic [7:0] got);
    logic       smp;
    logic [7:0] exp_b;
    exp_b = m_tx_cur;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, ~exp_b[i], 1'b1, 1'b1, 1'b0, smp);
      got[i] = smp;
    end
    check("read_byte", {24'd0, got}, {24'd0, exp_b});
    bit_cycle(mack, 1'b0, 1'b1, 1'b1, 1'b0, smp);
    if (mack == 1'b0) begin
      exp_txreq++;
      m_tx_cur = tx_next;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] g1, g2;
    logic       smp;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_tx_req", {31'd0, tx_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Write 0x3C to 0x50
    m_start();
    m_write_byte(8'hA0, 1, -1);
    m_write_byte(8'h3C, 0, -1);
    m_stop();
    check("wr_rx_data", {24'd0, rx_data}, 32'h3C);
    check("wr_rxv_cnt", rxv_cnt, 1);

    // Address mismatch and general call are both ignored
    m_start();
    m_write_byte(8'hA2, 1, -1);
    m_write_byte(8'h55, 0, -1);
    m_stop();
    m_start();
    m_write_byte(8'h00, 1, -1);
    m_write_byte(8'h77, 0, -1);
    m_stop();
    check("nomatch_rxv_cnt", rxv_cnt, 1);
    check("nomatch_rx_data", {24'd0, rx_data}, 32'h3C);

    // Read two bytes, ACK then NACK
    tx_next = 8'hC5;
    m_start();
    m_write_byte(8'hA1, 1, -1);
    tx_next = 8'h0F;
    m_read_byte(1'b0, g1);
    m_read_byte(1'b1, g2);
    m_stop();
    check("rd_byte0", {24'd0, g1}, 32'hC5);
    check("rd_byte1", {24'd0, g2}, 32'h0F);
    check("rd_txreq_cnt", txreq_cnt, 2);

    // Write then repeated start into a one-byte read
    m_start();
    m_write_byte(8'hA0, 1, -1);
    m_write_byte(8'h11, 0, -1);
    tx_next = 8'h6B;
    m_start();
    m_write_byte(8'hA1, 1, -1);
    m_read_byte(1'b1, g1);
    m_stop();
    check("sr_rx_data", {24'd0, rx_data}, 32'h11);
    check("sr_read", {24'd0, g1}, 32'h6B);
    check("sr_txreq_cnt", txreq_cnt, 3);
    check("sr_rxv_cnt", rxv_cnt, 2);

    // STOP after four bits of a data byte discards it
    m_start();
    m_write_byte(8'hA0, 1, -1);
    for (int i = 0; i < 4; i++) bit_cycle(i[0], 1'b0, 1'b1, 1'b1, 1'b0, smp);
    m_stop();
    check("abort_rxv_cnt", rxv_cnt, 2);

    // Reset in the middle of a read byte
    tx_next = 8'h96;
    m_start();
    m_write_byte(8'hA1, 1, -1);
    for (int i = 7; i >= 5; i--) bit_cycle(1'b1, ~m_tx_cur[i], 1'b1, 1'b1, 1'b0, smp);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("mrst_rx_data", {24'd0, rx_data}, 32'd0);
    check("mrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("mrst_tx_req", {31'd0, tx_req}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    m_busy = 0;
    m_stop();
    check("mrst_txreq_cnt", txreq_cnt, 4);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    m_start();
    m_write_byte(8'hA0, 1, -1);
    m_write_byte(8'h5A, 0, 4);
    m_stop();
    check("glitch_rx_data", {24'd0, rx_data}, 32'h5A);
`endif

    for (int t = 0; t < 25; t++) begin
      logic [6:0] a;
      logic       rw;
      int         n;
      int         ending;
      a       = ($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 7'($urandom_range(0, 127));
      rw      = 1'($urandom_range(0, 1));
      n       = $urandom_range(1, 3);
      ending  = $urandom_range(0, 2);
      tx_next = 8'($urandom);
      m_start();
      m_write_byte({a, rw}, 1, -1);
      if (rw == 1'b0) begin
        for (int k = 0; k < n; k++) m_write_byte(8'($urandom), 0, -1);
      end else if (m_busy) begin
        for (int k = 0; k < n; k++) begin
          tx_next = 8'($urandom);
          m_read_byte((k == n - 1), g1);
        end
      end
      if (ending == 0 && rw == 1'b0) begin
        for (int i = 0; i < $urandom_range(1, 7); i++)
          bit_cycle(1'($urandom), 1'b0, 1'b1, m_busy, 1'b0, smp);
        m_stop();
      end else if (ending == 1 && t != 24) begin
        repeat (2) @(posedge clk);
      end else begin
        m_stop();
      end
      check("rnd_txreq_cnt", txreq_cnt, exp_txreq);
      check("rnd_rxq_drained", rxq.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder): the other end of the bus from the team's I2C master.
- Samples SCL/SDA on the system clock, detects START/STOP, and matches a 7-bit address.
- Receives write bytes to a parallel output; serves read bytes from a parallel input.
- Drives SDA open-drain; SCL is never driven (no clock stretching).

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target responds to.
- SYNC_STAGES, 2, flip-flop synchronizer depth on scl_in/sda_in (min 2).
- FILT_LEN, 3, consecutive equal samples required by the glitch filter (used only with the optional feature).

Ports:
- clk, input, 1, system clock; SCL high/low phases must each be ≥ SYNC_STAGES+FILT_LEN+2 clk periods.
- rst, input, 1, reset; synchronous, active-high.
- scl_in, input, 1, raw SCL bus level.
- sda_in, input, 1, raw SDA bus level.
- sda_oe, output, 1, 1 = pull SDA low; 0 = release (external pull-up).
- rx_data, output, 8, last received write byte, MSB first on the bus.
- rx_valid, output, 1, one-cycle pulse when rx_data updates.
- tx_data, input, 8, byte to transmit; sampled on the cycle tx_req is high.
- tx_req, output, 1, one-cycle pulse: read byte needed now.
- busy, output, 1, high from an address match until STOP or a new START.

Behaviour:
- Reset values: sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0; state=IDLE.
- Front end: SYNC_STAGES-deep sync of SCL/SDA, then one delay register. Events are derived from synced vs delayed values:
  - scl_rise, scl_fall.
  - START: SDA 1->0 while SCL high.
  - STOP: SDA 0->1 while SCL high.
- Data bits are sampled on scl_rise, MSB first, into an 8-bit shift register with a 3-bit counter. sda_oe changes only on scl_fall, except STOP/START/rst, which release it immediately.
- States:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift 8 bits (7 address + R/W).
    - Match on the 8th rise -> ADDR_ACK, busy=1.
    - Mismatch -> IDLE with sda_oe=0.
  - ADDR_ACK: on the next scl_fall assert sda_oe=1; on the following scl_fall:
    - W: release sda_oe -> RX.
    - R: tx_req pulse, latch tx_data, drive MSB (sda_oe=~bit7) -> TX.
  - RX: on the 8th rise, rx_data <= shift, rx_valid pulse (same cycle) -> RX_ACK.
  - RX_ACK: on scl_fall assert sda_oe=1; on the next scl_fall release -> RX.
  - TX: drive the remaining bits on each scl_fall. After the 8th bit's scl_fall, release sda_oe -> TX_ACK.
  - TX_ACK: sample master ACK on scl_rise.
    - ACK (0): on scl_fall, tx_req pulse, latch tx_data, drive MSB -> TX.
    - NACK (1): -> WAIT_STOP with sda_oe=0.
  - WAIT_STOP: ignore bits until STOP/START.
- START in any state (repeated start): bit counter cleared -> ADDR, busy=0, sda_oe=0.
- STOP in any state: -> IDLE, busy=0, sda_oe=0. A partial byte is discarded; no rx_valid.
- Simultaneous START/STOP with scl edge cannot occur (SDA only changes with SCL high for these); if an event and scl_rise coincide, START/STOP wins.
- General-call address 7'h00 is not matched.
- Event latency: bus edge to internal event = SYNC_STAGES+1 cycles (+FILT_LEN with the filter).

Optional Feature:
- Macro I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: after the synchronizer, each line passes a FILT_LEN-sample majority/persistence filter. The filtered output changes only after FILT_LEN consecutive equal samples, so pulses shorter than FILT_LEN clks are suppressed. Latency grows by FILT_LEN.
- Undefined: the synchronizer output is used directly; FILT_LEN is unused.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP).
  - ADDR_W=7.
  - RW_WRITE=0, RW_READ=1.
  - I2C_ACK=0, I2C_NACK=1.
- Sub-module i2c_bus_sync: synchronizer + optional filter + edge detect; outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- Write: START, 0xA0 (0x50+W), 0x3C, STOP -> sda_oe=1 during both 9th clocks; rx_valid once with rx_data=8'h3C; busy 1 then 0 after STOP.
- Address mismatch: START, 0xA2, 0x55, STOP -> sda_oe stays 0 throughout, no rx_valid, busy=0.
- Read: START, 0xA1, tx_data=8'hC5, master ACK, then tx_data=8'h0F, master NACK, STOP:
  - SDA reads 0xC5 then 0x0F; tx_req pulses exactly twice.
  - State returns to IDLE with sda_oe=0.
- Repeated start: START, 0xA0, 0x11, Sr, 0xA1, read 1 byte NACK, STOP -> rx_data=8'h11, then one tx_req; ACK on both addresses.
- Abort/reset: STOP after 4 bits of a data byte -> no rx_valid, sda_oe=0. Assert rst mid-TX -> all outputs at reset values the next cycle.
- With I2C_SLAVE_GLITCH_FILTER_EN: inject a 1-clk SCL glitch mid-byte of write 0xA0/0x5A -> rx_data=8'h5A, bit count unaffected. Without the macro the same glitch corrupts the byte (expected).
